// File: rtl/npc_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : npc_fetch                                                  |
// | Brief    : fetch front end - owns the PC, issues imem word reads,     |
// |            buffers returned words and applies execute redirects.      |
// | Options  : FETCH_PERF_EN adds perf_fetch / perf_flush counters        |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module npc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redir_valid,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] redir_pc,
    input  logic [15:0] Imm16,
    input  logic [25:0] Imm26,
    input  logic [31:0] RA,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_flush,
`endif
    output logic        fault
);

    localparam int c_pw = $clog2(BUF_DEPTH);
    localparam int c_cw = c_pw + 1;
    localparam logic [c_cw:0] c_depth = (c_cw + 1)'(BUF_DEPTH);

    localparam logic [1:0] c_op_plus4  = 2'b00;
    localparam logic [1:0] c_op_branch = 2'b01;
    localparam logic [1:0] c_op_jump   = 2'b10;
    localparam logic [1:0] c_op_reg    = 2'b11;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_REDIR = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_pc;
    logic [c_cw-1:0] r_inflight;
    logic [c_cw-1:0] r_drop;
    logic [c_cw-1:0] r_count;
    logic [c_pw-1:0] r_tag_wr;
    logic [c_pw-1:0] r_tag_rd;
    logic [c_pw-1:0] r_buf_wr;
    logic [c_pw-1:0] r_buf_rd;
    logic            r_fault;
    logic [31:0]     r_tag_q    [BUF_DEPTH];
    logic [31:0]     r_buf_data [BUF_DEPTH];
    logic [31:0]     r_buf_pc   [BUF_DEPTH];

    logic [31:0]     w_p4;
    logic [31:0]     w_target;
    logic            w_redir;
    logic            w_take;
    logic            w_fault_evt;
    logic            w_grant;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;
    logic [c_cw-1:0] w_inflight_nxt;
    logic [c_cw:0]   w_used;

    assign w_p4 = redir_pc + 32'd4;

    always_comb begin
        w_target = w_p4;
        case (NPCOp)
            c_op_branch: w_target = w_p4 + {{14{Imm16[15]}}, Imm16, 2'b00};
            c_op_jump:   w_target = {w_p4[31:28], Imm26, 2'b00};
            c_op_reg:    w_target = RA;
            default:     w_target = w_p4;
        endcase
    end

    // A redirect (taken or faulting) always flushes; PLUS4 is ignored.
    assign w_redir     = redir_valid && (NPCOp != c_op_plus4) && (r_state != S_FAULT);
    assign w_fault_evt = w_redir && (w_target[1:0] != 2'b00);
    assign w_take      = w_redir && (w_target[1:0] == 2'b00);

    assign w_used         = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_grant        = imem_req && imem_gnt;
    assign w_resp         = imem_rvalid && (r_inflight != '0);
    assign w_push         = w_resp && (r_drop == '0) && !w_redir && (r_state != S_FAULT);
    assign w_pop          = instr_valid && instr_ready;
    assign w_inflight_nxt = r_inflight + c_cw'(w_grant) - c_cw'(w_resp);

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   imem_req    = (w_used < c_depth);
            S_REDIR: w_state_nxt = S_RUN;
            default: w_state_nxt = S_FAULT;
        endcase
        if (w_fault_evt) begin
            w_state_nxt = S_FAULT;
        end else if (w_take) begin
            w_state_nxt = S_REDIR;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_buf_wr   <= '0;
            r_buf_rd   <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_inflight_nxt;
            if (w_take) begin
                r_pc <= w_target;
            end else if (w_grant) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_grant) begin
                r_tag_wr <= r_tag_wr + c_pw'(1);
            end
            if (w_resp) begin
                r_tag_rd <= r_tag_rd + c_pw'(1);
            end
            // Everything still outstanding after this cycle belongs to the old stream.
            if (w_redir) begin
                r_drop <= w_inflight_nxt;
            end else if (w_resp && (r_drop != '0)) begin
                r_drop <= r_drop - c_cw'(1);
            end
            if (w_fault_evt) begin
                r_fault <= 1'b1;
            end
            if (w_redir) begin
                r_buf_wr <= '0;
                r_buf_rd <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_buf_wr <= r_buf_wr + c_pw'(1);
                end
                if (w_pop) begin
                    r_buf_rd <= r_buf_rd + c_pw'(1);
                end
                r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_tag_q[r_tag_wr] <= r_pc;
        end
        if (w_push) begin
            r_buf_data[r_buf_wr] <= imem_rdata;
            r_buf_pc[r_buf_wr]   <= r_tag_q[r_tag_rd];
        end
    end

    assign imem_addr   = r_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_buf_data[r_buf_rd] : 32'd0;
    assign instr_pc    = instr_valid ? r_buf_pc[r_buf_rd] : 32'd0;
    assign fault       = r_fault;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_fetch <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            if (w_push) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_take) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_flush = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_npc_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_npc_fetch                                               |
// | Brief    : randomized bench for npc_fetch against a queue-based model |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_npc_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam int          BUF_DEPTH = 4;
    localparam logic [31:0] c_key     = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redir_valid = 1'b0;
    logic [1:0]  NPCOp = 2'b00;
    logic [31:0] redir_pc = 32'd0;
    logic [15:0] Imm16 = 16'd0;
    logic [25:0] Imm26 = 26'd0;
    logic [31:0] RA = 32'd0;
    logic        fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    always #5 clk = ~clk;

    npc_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redir_valid (redir_valid),
        .NPCOp       (NPCOp),
        .redir_pc    (redir_pc),
        .Imm16       (Imm16),
        .Imm26       (Imm26),
        .RA          (RA),
`ifdef FETCH_PERF_EN
        .perf_fetch  (perf_fetch),
        .perf_flush  (perf_flush),
`endif
        .fault       (fault)
    );

    // Memory side: every granted address with its due cycle and a stale mark.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] mbuf[$];
    logic [31:0] m_pc;
    bit          m_hold;
    bit          m_fault;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          pops;
    logic [31:0] last_pop_pc;

    int          gnt_pct, ready_pct, lat_min, lat_extra, redir_pct;
    bit          force_redir, spur_rvalid;
    logic [1:0]  f_op;
    logic [31:0] f_pc, f_ra;
    logic [15:0] f_i16;
    logic [25:0] f_i26;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] target_of(input logic [1:0] op, input logic [31:0] pc,
                                              input logic [15:0] i16, input logic [25:0] i26,
                                              input logic [31:0] ra);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        case (op)
            2'b01:   return p4 + 32'($signed(i16)) * 32'd4;
            2'b10:   return (p4 & 32'hF000_0000) | ({6'd0, i26} << 2);
            2'b11:   return ra;
            default: return p4;
        endcase
    endfunction

    task automatic model_clear();
        memq.delete();
        mbuf.delete();
        m_pc    = RESET_PC;
        m_hold  = 1'b1;
        m_fault = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   32'(imem_req), 32'd0);
        check({tag, "_addr"},  imem_addr, RESET_PC);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_pc"},    instr_pc, 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    // One clock: entered and left just after a falling edge.
    task automatic step();
        bit          exp_req, exp_valid, grant, pop, rv, redir, take, fevt;
        logic [1:0]  op;
        logic [31:0] pc, ra, tgt;
        logic [15:0] i16;
        logic [25:0] i26;
        mreq_t       r;
        #1;
        exp_valid = (mbuf.size() != 0);
        exp_req   = !m_fault && !m_hold && ((memq.size() + mbuf.size()) < BUF_DEPTH);
        check("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("instr_pc", instr_pc, mbuf[0]);
            check("instr", instr, mbuf[0] ^ c_key);
        end
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("fault", 32'(fault), 32'(m_fault));

        imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        instr_ready = ($urandom_range(0, 99) < ready_pct);
        rv          = (memq.size() != 0) && (memq[0].due <= cyc);
        imem_rvalid = rv || spur_rvalid;
        imem_rdata  = rv ? (memq[0].addr ^ c_key) : $urandom;
        spur_rvalid = 1'b0;
        pop         = exp_valid && instr_ready;

        op  = 2'($urandom_range(0, 3));
        pc  = exp_valid ? mbuf[0] : $urandom;
        i16 = 16'($urandom);
        i26 = 26'($urandom);
        ra  = $urandom & 32'hFFFF_FFFC;
        redir = pop && ($urandom_range(0, 99) < redir_pct);
        if (force_redir) begin
            redir = 1'b1;
            op = f_op; pc = f_pc; i16 = f_i16; i26 = f_i26; ra = f_ra;
        end
        redir_valid = redir;
        NPCOp = op; redir_pc = pc; Imm16 = i16; Imm26 = i26; RA = ra;
        tgt   = target_of(op, pc, i16, i26, ra);
        take  = redir && (op != 2'b00) && !m_fault && (tgt[1:0] == 2'b00);
        fevt  = redir && (op != 2'b00) && !m_fault && (tgt[1:0] != 2'b00);
        grant = exp_req && imem_gnt;

        @(posedge clk);
        if (pop) begin
            last_pop_pc = instr_pc;
            void'(mbuf.pop_front());
            pops++;
        end
        if (rv) begin
            r = memq.pop_front();
            if (!r.stale && !take && !fevt && !m_fault) mbuf.push_back(r.addr);
        end
        if (grant) begin
            memq.push_back('{m_pc, cyc + lat_min + int'($urandom_range(0, lat_extra)), 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (take) begin
            foreach (memq[i]) memq[i].stale = 1'b1;
            mbuf.delete();
            m_pc = tgt;
        end
        if (fevt) begin
            m_fault = 1'b1;
            mbuf.delete();
        end
        m_hold      = take;
        force_redir = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; redir_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_vals("rst");
        rstn = 1'b1;
        model_clear();
    endtask

    // Reset asserted between clock edges, then a stray response after release.
    task automatic async_reset_pulse(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_vals(tag);
        imem_rvalid = 1'b0; redir_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
        spur_rvalid = 1'b1;
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] exp_pc);
        int p0;
        p0 = pops;
        for (int i = 0; i < 60 && pops == p0; i++) step();
        check({tag, "_seen"}, 32'(pops != p0), 32'd1);
        if (pops != p0) check(tag, last_pop_pc, exp_pc);
    endtask

    initial begin
        int p0;
        n_checks = 0; n_fail = 0; cyc = 0; pops = 0; last_pop_pc = 32'd0;
        force_redir = 1'b0; spur_rvalid = 1'b0;
        f_op = 2'b00; f_pc = 32'd0; f_ra = 32'd0; f_i16 = 16'd0; f_i26 = 26'd0;
        model_clear();

        // T1: streaming fetch, one-cycle memory
        gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_extra = 0; redir_pct = 0;
        do_reset();
        wait_pop("t1_first_pc", RESET_PC);
        p0 = pops;
        repeat (30) step();
        check("t1_no_gap", 32'(pops - p0), 32'd30);

        // T2: decode stall, buffer and in-flight saturate
        ready_pct = 0;
        repeat (10) step();
        #1;
        check("t2_req_low", 32'(imem_req), 32'd0);
        check("t2_valid", 32'(instr_valid), 32'd1);

        // T3: branch back with two words in flight
        ready_pct = 100;
        do_reset();
        ready_pct = 0; lat_min = 8;
        for (int i = 0; i < 12 && memq.size() < 2; i++) step();
        gnt_pct = 0;
        force_redir = 1'b1; f_op = 2'b01; f_pc = 32'h0000_3010; f_i16 = 16'hFFFC;
        step();
        gnt_pct = 100; ready_pct = 100; lat_min = 1;
        wait_pop("t3_target", 32'h0000_3004);

        // T4: jump then register redirect
        force_redir = 1'b1; f_op = 2'b10; f_pc = 32'h0FFF_FFFC; f_i26 = 26'h0000100;
        step();
        wait_pop("t4_jump", 32'h1000_0400);
        force_redir = 1'b1; f_op = 2'b11; f_ra = 32'h0000_4000;
        step();
        wait_pop("t4_reg", 32'h0000_4000);

        // T5: misaligned register target
        lat_extra = 2;
        force_redir = 1'b1; f_op = 2'b11; f_ra = 32'h0000_4002;
        step();
        #1;
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_valid", 32'(instr_valid), 32'd0);
        repeat (10) step();
        #1;
        check("t5_req_dead", 32'(imem_req), 32'd0);
        async_reset_pulse("t5_rst");

        // T6: random traffic with redirects colliding with pop/rvalid/grant
        gnt_pct = 80; ready_pct = 75; lat_min = 1; lat_extra = 3; redir_pct = 25;
        repeat (400) step();
        async_reset_pulse("t6_rst");
        repeat (60) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
